// File: rtl/stack_ctrl.sv
// stack_ctrl: stack-pointer unit for the processor data path.
// It produces the data-memory address for PUSH, POP and LOAD-SP.
// It tracks the pointer, the depth and the full/empty flags.
// An illegal operation puts the unit into a sticky FAULT state; the pointer never wraps.
// Optional feature: define STACK_HWM_EN to build the high-water-mark register behind hwm.
// Without STACK_HWM_EN, hwm is tied to zero.
module stack_ctrl #(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] STACK_TOP   = 8'hFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hAF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              fault_clr,
    output logic [ADDR_W-1:0] address,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] depth,
    output logic              full,
    output logic              empty,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [ADDR_W-1:0] hwm
);

    generate
        if (STACK_LIMIT >= STACK_TOP) begin : g_bad_params
            $error("stack_ctrl: STACK_LIMIT must be below STACK_TOP");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_OVF  = 2'b01;
    localparam logic [1:0] CODE_UNF  = 2'b10;
    localparam logic [1:0] CODE_LOAD = 2'b11;

    typedef enum logic {S_RUN, S_FAULT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] sp_nxt;
    logic              go_fault;
    logic [1:0]        code_nxt;
    logic              load_ok;

    // Status is derived straight from the pointer; a pop reads the slot above sp.
    assign depth   = STACK_TOP - sp;
    assign full    = (sp == STACK_LIMIT);
    assign empty   = (sp == STACK_TOP);
    assign fault   = (state == S_FAULT);
    assign address = op[1] ? (sp + ONE) : sp;
    assign load_ok = (load_val >= STACK_LIMIT) && (load_val <= STACK_TOP);

    // Decode the requested op into the next pointer or a fault with its cause.
    always_comb begin
        sp_nxt   = sp;
        go_fault = 1'b0;
        code_nxt = CODE_NONE;
        if (state == S_RUN) begin
            case (op)
                OP_PUSH: begin
                    if (full) begin
                        go_fault = 1'b1;
                        code_nxt = CODE_OVF;
                    end else begin
                        sp_nxt = sp - ONE;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        go_fault = 1'b1;
                        code_nxt = CODE_UNF;
                    end else begin
                        sp_nxt = sp + ONE;
                    end
                end
                OP_LOAD: begin
                    if (load_ok) begin
                        sp_nxt = load_val;
                    end else begin
                        go_fault = 1'b1;
                        code_nxt = CODE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    // RUN/FAULT state machine. It owns the pointer and the fault code.
    // In FAULT the pointer stays frozen until fault_clr is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RUN;
            sp         <= STACK_TOP;
            fault_code <= CODE_NONE;
        end else begin
            case (state)
                S_RUN: begin
                    sp <= sp_nxt;
                    if (go_fault) begin
                        state      <= S_FAULT;
                        fault_code <= code_nxt;
                    end
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        state      <= S_RUN;
                        fault_code <= CODE_NONE;
                    end
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

`ifdef STACK_HWM_EN
    logic [ADDR_W-1:0] hwm_q;
    logic [ADDR_W-1:0] depth_nxt;

    assign depth_nxt = STACK_TOP - sp_nxt;
    assign hwm       = hwm_q;

    // Track the deepest stack seen since the last reset or fault_clr, loads included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_q <= '0;
        end else if (fault_clr) begin
            hwm_q <= '0;
        end else if (depth_nxt > hwm_q) begin
            hwm_q <= depth_nxt;
        end
    end
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl: directed scenarios followed by randomized ops.
// Expected values come from a pointer/fault model kept in plain integers.
module tb_stack_ctrl;

    localparam int TOP = 8'hFF;
    localparam int LIM = 8'hAF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] load_val = 8'h00;
    logic       fault_clr = 1'b0;
    logic [7:0] address, sp, depth, hwm;
    logic       full, empty, fault;
    logic [1:0] fault_code;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_sp, m_fault, m_code, m_hwm;

    stack_ctrl #(.ADDR_W(8), .STACK_TOP(8'hFF), .STACK_LIMIT(8'hAF)) dut (
        .clk(clk), .rst(rst), .op(op), .load_val(load_val), .fault_clr(fault_clr),
        .address(address), .sp(sp), .depth(depth), .full(full), .empty(empty),
        .fault(fault), .fault_code(fault_code), .hwm(hwm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int hwm_exp();
`ifdef STACK_HWM_EN
        return m_hwm;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_sp = TOP; m_fault = 0; m_code = 0; m_hwm = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".sp"}, int'(sp), m_sp);
        chk({tag, ".depth"}, int'(depth), TOP - m_sp);
        chk({tag, ".full"}, int'(full), (m_sp == LIM) ? 1 : 0);
        chk({tag, ".empty"}, int'(empty), (m_sp == TOP) ? 1 : 0);
        chk({tag, ".fault"}, int'(fault), m_fault);
        chk({tag, ".code"}, int'(fault_code), m_code);
        chk({tag, ".hwm"}, int'(hwm), hwm_exp());
    endtask

    // Apply one op for one cycle: check address before the edge, state after it.
    task automatic step(input logic [1:0] o, input int lv, input logic clr, input string tag);
        int a_exp;
        @(negedge clk);
        op = o; load_val = 8'(lv); fault_clr = clr;
        #1;
        a_exp = o[1] ? ((m_sp + 1) % 256) : m_sp;
        chk({tag, ".addr"}, int'(address), a_exp);
        @(posedge clk);
        if (m_fault != 0) begin
            if (clr) begin m_fault = 0; m_code = 0; end
        end else begin
            case (o)
                2'b01: if (m_sp == LIM) begin m_fault = 1; m_code = 1; end else m_sp = m_sp - 1;
                2'b10: if (m_sp == TOP) begin m_fault = 1; m_code = 2; end else m_sp = m_sp + 1;
                2'b11: if (lv >= LIM && lv <= TOP) m_sp = lv; else begin m_fault = 1; m_code = 3; end
                default: ;
            endcase
        end
        if (clr) m_hwm = 0;
        else if (TOP - m_sp > m_hwm) m_hwm = TOP - m_sp;
        #1;
        check_state(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        op = 2'b00; fault_clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_state(tag);
        chk({tag, ".addr"}, int'(address), TOP);
        #1 rst = 1'b0;
    endtask

    initial begin
        int o, lv, c;
        model_reset();
        rst = 1'b1;
        #12;
        check_state("rst");
        rst = 1'b0;

        // reset addresses: hold reads sp, pop reads sp+1 (wraps to 00)
        step(2'b00, 0, 1'b0, "t1_hold");
        chk("t1_addr_hold", int'(address), 8'hFF);
        step(2'b10, 0, 1'b0, "t1_pop");
        step(2'b00, 0, 1'b1, "t1_clr");

        // fill to the limit, then overflow
        for (int i = 0; i < 80; i++) step(2'b01, 0, 1'b0, "t2_push");
        chk("t2_full", int'(full), 1);
        chk("t2_depth", int'(depth), 80);
        step(2'b01, 0, 1'b0, "t2_ovf");
        chk("t2_ovf_code", int'(fault_code), 1);
        step(2'b01, 0, 1'b0, "t2_push_in_fault");
        chk("t2_sp_frozen", int'(sp), 8'hAF);
        step(2'b00, 0, 1'b1, "t2_clr");

        // underflow, then clear together with push
        pulse_reset("t3_rst");
        step(2'b10, 0, 1'b0, "t3_unf");
        chk("t3_unf_code", int'(fault_code), 2);
        step(2'b01, 0, 1'b1, "t3_clr_push");
        chk("t3_sp_after_clr", int'(sp), 8'hFF);

        // loads
        step(2'b11, 8'hC0, 1'b0, "t4_load_c0");
        chk("t4_depth", int'(depth), 63);
        step(2'b11, 8'h10, 1'b0, "t4_bad_load");
        chk("t4_bad_code", int'(fault_code), 3);
        step(2'b00, 0, 1'b1, "t4_clr");
        step(2'b11, 8'hFF, 1'b0, "t4_load_ff");

        // pop address and asynchronous reset mid-sequence
        pulse_reset("t5_rst");
        step(2'b01, 0, 1'b0, "t5_push");
        step(2'b01, 0, 1'b0, "t5_push");
        step(2'b01, 0, 1'b0, "t5_push");
        step(2'b10, 0, 1'b0, "t5_pop");
        chk("t5_sp_after_pop", int'(sp), 8'hFD);
        step(2'b01, 0, 1'b0, "t5_push");
        pulse_reset("t5_async");

        // high-water mark
        for (int i = 0; i < 5; i++) step(2'b01, 0, 1'b0, "t6_push");
        for (int i = 0; i < 3; i++) step(2'b10, 0, 1'b0, "t6_pop");
        step(2'b01, 0, 1'b0, "t6_push");
        chk("t6_depth", int'(depth), 3);
`ifdef STACK_HWM_EN
        chk("t6_hwm", int'(hwm), 5);
`else
        chk("t6_hwm", int'(hwm), 0);
`endif
        step(2'b00, 0, 1'b1, "t6_clr");
        chk("t6_hwm_clr", int'(hwm), 0);

        // randomized ops, weighted towards push so the full boundary gets reached
        for (int i = 0; i < 1500; i++) begin
            c = $urandom_range(0, 9);
            o = (c < 4) ? 1 : (c < 7) ? 2 : (c < 8) ? 0 : 3;
            lv = ($urandom_range(0, 1) == 1) ? $urandom_range(LIM, TOP) : $urandom_range(0, 255);
            if (m_fault != 0) c = ($urandom_range(0, 2) == 0) ? 1 : 0;
            else if (o == 0) c = ($urandom_range(0, 7) == 0) ? 1 : 0;
            else c = 0;
            if ($urandom_range(0, 199) == 0) pulse_reset("rnd_rst");
            else step(2'(o), lv, c[0], "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
